// File: rtl/ibuffer_col_stream.sv
// Column input buffer: DEPTH-word queue feeding a LANES-element shift register, emitted one element per ENDown.
// Optional IBUF_COL_UNDERRUN_EN adds a sticky Underrun flag backed by an 8-bit saturating underrun counter.
module ibuffer_col_stream #(
   parameter int DATA_W = 8,
   parameter int LANES  = 4,
   parameter int DEPTH  = 4
) (
   input  logic                         CLK,
   input  logic                         RSTN,
   input  logic                         IValid,
   output logic                         IReady,
   input  logic [DATA_W*LANES-1:0]      IWord,
   input  logic                         Flush,
   input  logic                         ENDown,
   output logic [DATA_W-1:0]            OD,
   output logic                         ENShift,
   output logic [$clog2(DEPTH+1)-1:0]   Count,
   output logic                         Empty,
   output logic                         Underrun
);

   localparam int WW = DATA_W * LANES;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam int RW = $clog2(LANES + 1);

   logic [WW-1:0]     mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [RW-1:0]     rem_q, rem_d;
   logic [WW-1:0]     sr_q, sr_d;
   logic [DATA_W-1:0] od_q, od_d;
   logic              enshift_q;
   logic              full_s, push_s, load_s;

   assign full_s  = (count_q == CW'(DEPTH));
   assign IReady  = ~full_s;
   assign OD      = od_q;
   assign ENShift = enshift_q;
   assign Count   = count_q;
   assign Empty   = (count_q == {CW{1'b0}}) && (rem_q == {RW{1'b0}});

   // Full queue refuses a push even when a pop happens in the same cycle
   assign push_s = IValid & ~full_s & ~Flush;
   assign load_s = ~Flush & (count_q != {CW{1'b0}}) &
                   ((rem_q == {RW{1'b0}}) | (ENDown & (rem_q == RW'(1))));

   // Next-state for shift register, element counter, queue pointers and output element
   always_comb begin
      sr_d     = sr_q;
      rem_d    = rem_q;
      od_d     = {DATA_W{1'b0}};
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (Flush) begin
         sr_d     = {WW{1'b0}};
         rem_d    = {RW{1'b0}};
         count_d  = {CW{1'b0}};
         rd_ptr_d = {PW{1'b0}};
         wr_ptr_d = {PW{1'b0}};
      end else begin
         if (ENDown && (rem_q != {RW{1'b0}})) begin
            od_d  = sr_q[WW-1 -: DATA_W];
            sr_d  = {sr_q[WW-DATA_W-1:0], {DATA_W{1'b0}}};
            rem_d = rem_q - RW'(1);
         end else begin
            od_d  = {DATA_W{1'b0}};
         end
         // A load overrides the shift so the last element and the next word meet with no bubble
         if (load_s) begin
            sr_d     = mem_q[rd_ptr_q];
            rem_d    = RW'(LANES);
            rd_ptr_d = rd_ptr_q + PW'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         count_d = count_q + CW'(push_s) - CW'(load_s);
      end
   end

   // Datapath and control state registers
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         sr_q      <= {WW{1'b0}};
         rem_q     <= {RW{1'b0}};
         od_q      <= {DATA_W{1'b0}};
         count_q   <= {CW{1'b0}};
         rd_ptr_q  <= {PW{1'b0}};
         wr_ptr_q  <= {PW{1'b0}};
         enshift_q <= 1'b0;
      end else begin
         sr_q      <= sr_d;
         rem_q     <= rem_d;
         od_q      <= od_d;
         count_q   <= count_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         enshift_q <= ENDown;
      end
   end

   // Word queue storage
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {WW{1'b0}};
         end
      end else if (push_s) begin
         mem_q[wr_ptr_q] <= IWord;
      end
   end

`ifdef IBUF_COL_UNDERRUN_EN
   logic [7:0] urun_cnt_q, urun_cnt_d;

   // Saturating count of ENDown pulses that found no element to emit; Flush leaves it alone
   always_comb begin
      urun_cnt_d = urun_cnt_q;
      if (ENDown && (rem_q == {RW{1'b0}}) && (urun_cnt_q != 8'hFF)) begin
         urun_cnt_d = urun_cnt_q + 8'd1;
      end else begin
         urun_cnt_d = urun_cnt_q;
      end
   end

   // Underrun counter register
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         urun_cnt_q <= 8'd0;
      end else begin
         urun_cnt_q <= urun_cnt_d;
      end
   end

   assign Underrun = (urun_cnt_q != 8'd0);
`else
   assign Underrun = 1'b0;
`endif

endmodule

// File: tb/tb_ibuffer_col_stream.sv
// Self-checking bench for ibuffer_col_stream: directed scenarios plus random traffic against a queue-based model.
module tb_ibuffer_col_stream;
   localparam int DATA_W = 8;
   localparam int LANES  = 4;
   localparam int DEPTH  = 4;
   localparam int WW     = DATA_W * LANES;
   localparam int CW     = $clog2(DEPTH + 1);

   logic CLK = 1'b0;
   logic RSTN, IValid, IReady, Flush, ENDown, ENShift, Empty, Underrun;
   logic [WW-1:0]     IWord;
   logic [DATA_W-1:0] OD;
   logic [CW-1:0]     Count;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: queued words, elements still to emit from the current word, last registered outputs
   logic [WW-1:0]     m_q [$];
   logic [DATA_W-1:0] m_cur [$];
   logic [DATA_W-1:0] m_od;
   logic              m_ensh;
   logic              m_urun;

   ibuffer_col_stream #(.DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH)) dut (
      .CLK(CLK), .RSTN(RSTN), .IValid(IValid), .IReady(IReady), .IWord(IWord),
      .Flush(Flush), .ENDown(ENDown), .OD(OD), .ENShift(ENShift), .Count(Count),
      .Empty(Empty), .Underrun(Underrun)
   );

   always #5 CLK = ~CLK;

   function automatic void model_reset();
      m_q.delete();
      m_cur.delete();
      m_od   = '0;
      m_ensh = 1'b0;
      m_urun = 1'b0;
   endfunction

   function automatic logic exp_urun();
`ifdef IBUF_COL_UNDERRUN_EN
      return m_urun;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [DATA_W-1:0] lane(input logic [WW-1:0] w, input int i);
      return w[WW-1-i*DATA_W -: DATA_W];
   endfunction

   // Drive one cycle of inputs, advance the model over the edge, return #1 after the edge
   task automatic tick(input logic v, input logic [WW-1:0] w, input logic en, input logic fl);
      logic acc;
      logic [WW-1:0] head;
      @(negedge CLK);
      IValid = v; IWord = w; ENDown = en; Flush = fl;
      acc = v && (m_q.size() < DEPTH);
      @(posedge CLK);
      m_ensh = en;
      if (en && m_cur.size() == 0) m_urun = 1'b1;
      m_od = '0;
      if (fl) begin
         m_q.delete();
         m_cur.delete();
      end else begin
         if (en && m_cur.size() > 0) m_od = m_cur.pop_front();
         if (m_cur.size() == 0 && m_q.size() > 0) begin
            head = m_q.pop_front();
            for (int i = 0; i < LANES; i++) m_cur.push_back(lane(head, i));
         end
         if (acc) m_q.push_back(w);
      end
      #1;
   endtask

   task automatic test_reset();
      RSTN = 1'b0; IValid = 1'b0; IWord = '0; ENDown = 1'b0; Flush = 1'b0;
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      n_tests++;
      if (OD !== 8'h00 || ENShift !== 1'b0) begin
         n_fail++; $display("FAIL reset_out: OD=%h ENShift=%b required 00/0", OD, ENShift);
      end
      n_tests++;
      if (Count !== 3'd0 || Empty !== 1'b1 || IReady !== 1'b1 || Underrun !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_status: Count=%0d Empty=%b IReady=%b Underrun=%b required 0/1/1/0",
                  Count, Empty, IReady, Underrun);
      end
      @(negedge CLK);
      RSTN = 1'b1;
   endtask

   task automatic test_basic(input logic [WW-1:0] w, input string name);
      tick(1'b1, w, 1'b0, 1'b0);
      tick(1'b0, '0, 1'b0, 1'b0);
      for (int i = 0; i < LANES; i++) begin
         tick(1'b0, '0, 1'b1, 1'b0);
         n_tests++;
         if (OD !== lane(w, i) || OD !== m_od || ENShift !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_lane%0d: OD=%h ENShift=%b required %h/1", name, i, OD, ENShift, lane(w, i));
         end
      end
      tick(1'b0, '0, 1'b0, 1'b0);
      n_tests++;
      if (Empty !== 1'b1 || OD !== 8'h00 || ENShift !== 1'b0) begin
         n_fail++; $display("FAIL %s_end: Empty=%b OD=%h ENShift=%b required 1/00/0", name, Empty, OD, ENShift);
      end
   endtask

   task automatic test_back_to_back();
      logic [WW-1:0] a, b, w;
      logic [CW-1:0] exp_cnt;
      a = 32'hA1A2A3A4;
      b = 32'hB1B2B3B4;
      tick(1'b1, a, 1'b0, 1'b0);
      tick(1'b1, b, 1'b0, 1'b0);
      n_tests++;
      if (Count !== 3'd1) begin
         n_fail++; $display("FAIL b2b_count_pre: Count=%0d required 1", Count);
      end
      for (int i = 0; i < 2 * LANES; i++) begin
         tick(1'b0, '0, 1'b1, 1'b0);
         w = (i < LANES) ? a : b;
         exp_cnt = (i < LANES - 1) ? 3'd1 : 3'd0;
         n_tests++;
         if (OD !== lane(w, i % LANES) || Count !== exp_cnt || Count !== CW'(m_q.size())) begin
            n_fail++;
            $display("FAIL b2b_elem%0d: OD=%h Count=%0d required %h/%0d", i, OD, Count, lane(w, i % LANES), exp_cnt);
         end
      end
      tick(1'b0, '0, 1'b0, 1'b0);
      n_tests++;
      if (Empty !== 1'b1) begin
         n_fail++; $display("FAIL b2b_empty: Empty=%b required 1", Empty);
      end
   endtask

   task automatic test_full();
      int guard;
      for (int i = 0; i < 5; i++) tick(1'b1, $urandom, 1'b0, 1'b0);
      n_tests++;
      if (Count !== 3'd4 || IReady !== 1'b0) begin
         n_fail++; $display("FAIL full_level: Count=%0d IReady=%b required 4/0", Count, IReady);
      end
      tick(1'b1, $urandom, 1'b0, 1'b0);
      n_tests++;
      if (Count !== 3'd4 || IReady !== 1'b0) begin
         n_fail++; $display("FAIL full_refuse: Count=%0d IReady=%b required 4/0", Count, IReady);
      end
      for (int i = 0; i < LANES; i++) begin
         tick(1'b0, '0, 1'b1, 1'b0);
         n_tests++;
         if (OD !== m_od || IReady !== (i == LANES - 1) || Count !== CW'(m_q.size())) begin
            n_fail++;
            $display("FAIL full_pop%0d: OD=%h IReady=%b Count=%0d required %h/%b/%0d",
                     i, OD, IReady, Count, m_od, (i == LANES - 1), m_q.size());
         end
      end
      guard = 0;
      while ((m_q.size() > 0 || m_cur.size() > 0) && guard < 64) begin
         tick(1'b0, '0, 1'b1, 1'b0);
         guard++;
         n_tests++;
         if (OD !== m_od) begin
            n_fail++; $display("FAIL full_drain: OD=%h required %h", OD, m_od);
         end
      end
      n_tests++;
      if (Empty !== 1'b1 || guard >= 64) begin
         n_fail++; $display("FAIL full_drained: Empty=%b guard=%0d required 1/<64", Empty, guard);
      end
   endtask

   task automatic test_underrun();
      logic exp_u;
`ifdef IBUF_COL_UNDERRUN_EN
      exp_u = 1'b1;
`else
      exp_u = 1'b0;
`endif
      tick(1'b0, '0, 1'b1, 1'b0);
      n_tests++;
      if (OD !== 8'h00 || ENShift !== 1'b1 || Underrun !== exp_u || Underrun !== exp_urun()) begin
         n_fail++; $display("FAIL underrun_hit: OD=%h ENShift=%b Underrun=%b required 00/1/%b", OD, ENShift, Underrun, exp_u);
      end
      tick(1'b0, '0, 1'b0, 1'b0);
      tick(1'b0, '0, 1'b0, 1'b0);
      n_tests++;
      if (Underrun !== exp_u || ENShift !== 1'b0) begin
         n_fail++; $display("FAIL underrun_sticky: Underrun=%b ENShift=%b required %b/0", Underrun, ENShift, exp_u);
      end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 4; i++) tick(1'b1, $urandom, 1'b0, 1'b0);
      n_tests++;
      if (Count !== 3'd3) begin
         n_fail++; $display("FAIL flush_fill: Count=%0d required 3", Count);
      end
      for (int i = 0; i < 2; i++) begin
         tick(1'b0, '0, 1'b1, 1'b0);
         n_tests++;
         if (OD !== m_od) begin
            n_fail++; $display("FAIL flush_emit%0d: OD=%h required %h", i, OD, m_od);
         end
      end
      tick(1'b1, $urandom, 1'b1, 1'b1);
      n_tests++;
      if (Count !== 3'd0 || Empty !== 1'b1 || OD !== 8'h00 || ENShift !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_clear: Count=%0d Empty=%b OD=%h ENShift=%b required 0/1/00/1", Count, Empty, OD, ENShift);
      end
      tick(1'b0, '0, 1'b1, 1'b0);
      n_tests++;
      if (OD !== 8'h00 || Empty !== 1'b1 || Underrun !== exp_urun()) begin
         n_fail++; $display("FAIL flush_after: OD=%h Empty=%b Underrun=%b required 00/1/%b", OD, Empty, Underrun, exp_urun());
      end
   endtask

   task automatic test_random();
      logic v, en, fl;
      for (int c = 0; c < 600; c++) begin
         v  = ($urandom_range(0, 99) < 45);
         en = ($urandom_range(0, 99) < 60);
         fl = ($urandom_range(0, 99) < 3);
         tick(v, $urandom, en, fl);
         n_tests++;
         if (OD !== m_od || ENShift !== m_ensh || Count !== CW'(m_q.size()) ||
             Empty !== (m_q.size() == 0 && m_cur.size() == 0) ||
             IReady !== (m_q.size() < DEPTH) || Underrun !== exp_urun()) begin
            n_fail++;
            $display("FAIL random_c%0d: OD=%h ENS=%b Cnt=%0d Emp=%b Rdy=%b Urn=%b required %h/%b/%0d/%b/%b/%b",
                     c, OD, ENShift, Count, Empty, IReady, Underrun, m_od, m_ensh, m_q.size(),
                     (m_q.size() == 0 && m_cur.size() == 0), (m_q.size() < DEPTH), exp_urun());
         end
      end
   endtask

   task automatic test_reset_midstream();
      tick(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
      tick(1'b1, 32'hCAFEF00D, 1'b0, 1'b0);
      tick(1'b0, '0, 1'b1, 1'b0);
      tick(1'b0, '0, 1'b1, 1'b0);
      #1;
      RSTN = 1'b0;
      #1;
      n_tests++;
      if (OD !== 8'h00 || ENShift !== 1'b0 || Count !== 3'd0 || Empty !== 1'b1 || Underrun !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset: OD=%h ENShift=%b Count=%0d Empty=%b Underrun=%b required 00/0/0/1/0",
                  OD, ENShift, Count, Empty, Underrun);
      end
      model_reset();
      IValid = 1'b0; ENDown = 1'b0; Flush = 1'b0;
      @(negedge CLK);
      RSTN = 1'b1;
      test_basic(32'h01020304, "post_reset");
   endtask

   initial begin
      test_reset();
      test_basic(32'h11223344, "basic");
      test_back_to_back();
      test_full();
      test_underrun();
      test_flush();
      test_random();
      test_reset_midstream();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
